// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and helpers
// used by the register-file slave and its address decoder.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned MAX_DATA_WIDTH = 64;
   localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

   // Width of a register index; a single-register file still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Byte-wise merge at the widest legal bus width; callers zero-extend and truncate.
   function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < int'(MAX_STRB_WIDTH); i++) begin
         if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi4_lite_regfile_slave_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Maps a byte address to a register index and flags accesses outside the file.
module axi4_lite_addr_decode
   import axi4_lite_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic [ADDR_WIDTH-1:0]            addr,
   output logic [idx_width(NUM_REGS)-1:0]   idx,
   output logic                             err
);

   localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] word;

   // Sub-word address bits drop out here, so misaligned accesses hit the containing word.
   assign word = (addr - BASE_ADDR) >> SHIFT;
   assign idx  = word[idx_width(NUM_REGS)-1:0];
   assign err  = (addr < BASE_ADDR) || (word >= ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave over a flat register file with byte strobes, independent AW/W
// acceptance, SLVERR on out-of-range accesses and back-pressured B/R channels.
module axi4_lite_regfile_slave
   import axi4_lite_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                             clk,
   input  logic                             reset,
   axi4_lite_regfile_slave_if.slave         bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_out
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned IDX_WIDTH  = idx_width(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   wr_state_e             wstate_q;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;

   rd_state_e             rstate_q;
   logic                  arready_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  wr_commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic                  wr_err;
   logic [IDX_WIDTH-1:0]  rd_idx;
   logic                  rd_err;

   assign aw_hs = bus.awvalid & awready_q;
   assign w_hs  = bus.wvalid & wready_q;
   assign ar_hs = bus.arvalid & arready_q;

   // Whichever half arrived earlier comes from its holding register.
   assign wr_addr = (wstate_q == W_ADDR) ? awaddr_q : bus.awaddr;
   assign wr_data = (wstate_q == W_DATA) ? wdata_q : bus.wdata;
   assign wr_strb = (wstate_q == W_DATA) ? wstrb_q : bus.wstrb;

   assign wr_commit = ((wstate_q == W_IDLE) & aw_hs & w_hs) |
                      ((wstate_q == W_ADDR) & w_hs) |
                      ((wstate_q == W_DATA) & aw_hs);

   assign wr_merged = DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(regs_q[wr_idx]),
                                             MAX_DATA_WIDTH'(wr_data),
                                             MAX_STRB_WIDTH'(wr_strb)));

   axi4_lite_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_wr_decode (
      .addr (wr_addr),
      .idx  (wr_idx),
      .err  (wr_err)
   );

   axi4_lite_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_rd_decode (
      .addr (bus.araddr),
      .idx  (rd_idx),
      .err  (rd_err)
   );

   // Write channel FSM; also owns the register array.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= '0;
      end else if (wr_commit) begin
         if (!wr_err) regs_q[wr_idx] <= wr_merged;
         bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
         bvalid_q  <= 1'b1;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         wstate_q  <= W_RESP;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               wready_q  <= 1'b1;
               if (aw_hs) begin
                  awaddr_q  <= bus.awaddr;
                  awready_q <= 1'b0;
                  wstate_q  <= W_ADDR;
               end else if (w_hs) begin
                  wdata_q  <= bus.wdata;
                  wstrb_q  <= bus.wstrb;
                  wready_q <= 1'b0;
                  wstate_q <= W_DATA;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Read channel FSM; sampling regs_q here returns the pre-write value on a collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  rdata_q   <= rd_err ? '0 : regs_q[rd_idx];
                  rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rstate_q  <= R_RESP;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.awready = awready_q & reset;
   assign bus.wready  = wready_q & reset;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q & reset;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;

   for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_regs_out
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
   end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Scoreboard bench for the AXI4-Lite register-file slave (32-bit, 16 registers).
module tb_axi4_lite_regfile_slave;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned NR = 16;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   logic               clk;
   logic               reset;
   logic [NR*DW-1:0]   regs_out;

   int unsigned        n_checks;
   int unsigned        n_fail;
   logic [31:0]        model [NR];
   logic [1:0]         b_q [$];
   r_exp_t             r_q [$];

   axi4_lite_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axi4_lite_regfile_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .BASE_ADDR  (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .regs_out (regs_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic check_regs(input string tag);
      for (int k = 0; k < int'(NR); k++) check_eq(tag, 64'(regs_out[k*DW +: DW]), 64'(model[k]));
   endtask

   task automatic clear_model();
      for (int k = 0; k < int'(NR); k++) model[k] = '0;
   endtask

   // Called at a negedge; W may lead AW (or vice versa) by the given delays.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay, input int w_delay);
      logic [31:0] word;
      bit          err;
      bit          aw_done;
      bit          w_done;
      bit          aw_hs;
      bit          w_hs;
      int          cyc;
      word    = addr >> 2;
      err     = (word >= 32'(NR));
      aw_done = 1'b0;
      w_done  = 1'b0;
      cyc     = 0;
      b_q.push_back(err ? 2'b10 : 2'b00);
      while (!(aw_done && w_done) && cyc < 50) begin
         bus.awaddr  = addr;
         bus.awvalid = !aw_done && (cyc >= aw_delay);
         bus.wdata   = data;
         bus.wstrb   = strb;
         bus.wvalid  = !w_done && (cyc >= w_delay);
         if (cyc > 0) check_eq("b_early", 64'(bus.bvalid), 64'(0));
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         @(posedge clk);
         if (aw_hs) aw_done = 1'b1;
         if (w_hs) w_done = 1'b1;
         @(negedge clk);
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check_eq("wr_handshake", 64'(aw_done && w_done), 64'(1));
      if (!err) model[word[3:0]] = model_merge(model[word[3:0]], data, strb);
      check_eq("b_latency", 64'(bus.bvalid), 64'(1));
      check_regs("regs_out_after_write");
   endtask

   task automatic axi_read(input logic [31:0] addr);
      logic [31:0] word;
      bit          err;
      bit          done;
      bit          hs;
      int          cyc;
      r_exp_t      e;
      word   = addr >> 2;
      err    = (word >= 32'(NR));
      e.data = err ? 32'h0 : model[word[3:0]];
      e.resp = err ? 2'b10 : 2'b00;
      r_q.push_back(e);
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 50) begin
         bus.araddr  = addr;
         bus.arvalid = 1'b1;
         hs = bus.arready;
         @(posedge clk);
         if (hs) done = 1'b1;
         @(negedge clk);
         cyc++;
      end
      bus.arvalid = 1'b0;
      check_eq("rd_handshake", 64'(done), 64'(1));
      check_eq("r_latency", 64'(bus.rvalid), 64'(1));
   endtask

   task automatic wait_b_done();
      int n;
      n = 0;
      while (bus.bvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("b_done", 64'(bus.bvalid), 64'(0));
   endtask

   task automatic wait_r_done();
      int n;
      n = 0;
      while (bus.rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("r_done", 64'(bus.rvalid), 64'(0));
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_bvalid", 64'(bus.bvalid), 64'(0));
      check_eq("rst_rvalid", 64'(bus.rvalid), 64'(0));
      check_eq("rst_bresp", 64'(bus.bresp), 64'(0));
      check_eq("rst_rresp", 64'(bus.rresp), 64'(0));
      check_eq("rst_rdata", 64'(bus.rdata), 64'(0));
      check_eq("rst_awready", 64'(bus.awready), 64'(0));
      check_eq("rst_wready", 64'(bus.wready), 64'(0));
      check_eq("rst_arready", 64'(bus.arready), 64'(0));
      check_regs("rst_regs_out");
   endtask

   task automatic check_readies_up();
      check_eq("rdy_awready", 64'(bus.awready), 64'(1));
      check_eq("rdy_wready", 64'(bus.wready), 64'(1));
      check_eq("rdy_arready", 64'(bus.arready), 64'(1));
   endtask

   // Scoreboard: a response is consumed on the edge following a valid&ready sample.
   always @(negedge clk) begin
      #1;
      if (reset) begin
         if (bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) check_eq("b_spurious", 64'(bus.bvalid), 64'(0));
            else check_eq("bresp", 64'(bus.bresp), 64'(b_q.pop_front()));
         end
         if (bus.rvalid && bus.rready) begin
            if (r_q.size() == 0) begin
               check_eq("r_spurious", 64'(bus.rvalid), 64'(0));
            end else begin
               r_exp_t e;
               e = r_q.pop_front();
               check_eq("rdata", 64'(bus.rdata), 64'(e.data));
               check_eq("rresp", 64'(bus.rresp), 64'(e.resp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      clear_model();

      repeat (2) begin
         @(negedge clk);
         check_reset_outputs();
      end
      reset = 1'b1;
      @(negedge clk);
      check_readies_up();

      // Simultaneous AW/W, then read back including a misaligned alias.
      axi_write(32'h10, 32'hCEEB_2006, 4'hF, 0, 0);
      wait_b_done();
      axi_read(32'h10);
      wait_r_done();
      axi_read(32'h13);
      wait_r_done();

      // W leads AW by three cycles with a partial strobe.
      axi_write(32'h14, 32'h1122_3344, 4'hF, 0, 0);
      wait_b_done();
      axi_write(32'h14, 32'hAABB_CCDD, 4'b0101, 3, 0);
      wait_b_done();
      axi_read(32'h14);
      wait_r_done();

      // AW leads W; then an all-zero strobe leaves the register alone.
      axi_write(32'h18, 32'h1234_5678, 4'b1000, 0, 2);
      wait_b_done();
      axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0);
      wait_b_done();
      axi_read(32'h10);
      wait_r_done();

      // Last valid register and the first out-of-range address.
      axi_write(32'h3C, 32'h0BAD_F00D, 4'hF, 0, 0);
      wait_b_done();
      axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0);
      wait_b_done();
      axi_read(32'h40);
      wait_r_done();
      axi_read(32'h3C);
      wait_r_done();

      // Back-pressure on B and R.
      bus.bready = 1'b0;
      axi_write(32'h20, 32'h5A5A_5A5A, 4'hF, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_bvalid", 64'(bus.bvalid), 64'(1));
         check_eq("bp_bresp", 64'(bus.bresp), 64'(0));
         check_eq("bp_awready", 64'(bus.awready), 64'(0));
         check_eq("bp_wready", 64'(bus.wready), 64'(0));
         @(negedge clk);
      end
      bus.bready = 1'b1;
      wait_b_done();
      check_eq("bp_awready_back", 64'(bus.awready), 64'(1));
      bus.rready = 1'b0;
      axi_read(32'h20);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_rvalid", 64'(bus.rvalid), 64'(1));
         check_eq("bp_rdata", 64'(bus.rdata), 64'(model[8]));
         check_eq("bp_rresp", 64'(bus.rresp), 64'(0));
         check_eq("bp_arready", 64'(bus.arready), 64'(0));
         @(negedge clk);
      end
      bus.rready = 1'b1;
      wait_r_done();

      // Reset while AW is held waiting for W.
      bus.awaddr  = 32'h24;
      bus.awvalid = 1'b1;
      check_eq("mid_awready", 64'(bus.awready), 64'(1));
      @(negedge clk);
      bus.awvalid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      clear_model();
      check_reset_outputs();
      reset = 1'b1;
      @(negedge clk);
      check_readies_up();
      repeat (3) begin
         check_eq("mid_no_bvalid", 64'(bus.bvalid), 64'(0));
         @(negedge clk);
      end
      check_eq("mid_reg9", 64'(regs_out[9*DW +: DW]), 64'(0));
      axi_write(32'h24, 32'h0F0F_1234, 4'hF, 0, 0);
      wait_b_done();
      axi_read(32'h24);
      wait_r_done();

      // Mixed traffic, some out of range.
      for (int i = 0; i < 12; i++) begin
         axi_write(32'($urandom_range(0, 19)) << 2, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         wait_b_done();
         axi_read((32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3)));
         wait_r_done();
      end

      repeat (3) @(negedge clk);
      check_eq("b_queue_empty", 64'(b_q.size()), 64'(0));
      check_eq("r_queue_empty", 64'(r_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
